// File: rtl/polyphase_partial_sum.sv
// polyphase_partial_sum: folds each 512-sample windowed frame into 64 partial sums Y[i] and
// streams them out of a ping-pong bank pair over a valid/ready interface.
module polyphase_partial_sum #(
   parameter int IN_W  = 16,
   parameter int ACC_W = IN_W + 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  windowed_sample,
   input  logic                    wso_valid,
   output logic signed [ACC_W-1:0] y_data,
   output logic [5:0]              y_idx,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic                    y_last,
   output logic                    overflow
);
   typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
   state_t state, state_n;
   logic [8:0] cnt;
   logic wbank, rbank, drop;
   logic [1:0] full, full_eff, set_mask, clr_mask;
   logic s1_valid, s1_last, s1_bank;
   logic [5:0] s1_i, rd_idx;
   logic [2:0] s1_j;
   logic signed [ACC_W-1:0] s1_sample, s1_rd;
   logic signed [ACC_W-1:0] acc [128];
   logic set_any, wb, wb_free, start, take, load, advance, done;
   // A frame finishing in S2 toggles the write bank one edge late, so look through it here.
   assign set_any  = s1_valid & s1_last;
   assign set_mask = set_any ? (s1_bank ? 2'b10 : 2'b01) : 2'b00;
   assign clr_mask = done ? (rbank ? 2'b10 : 2'b01) : 2'b00;
   assign full_eff = full | set_mask;
   assign wb       = wbank ^ set_any;
   assign wb_free  = !full[wb] || clr_mask[wb];
   assign start    = wso_valid && cnt == 9'd0;
   assign take     = wso_valid && (start ? wb_free : !drop);
   assign rd_idx   = load ? 6'd0 : y_idx + 6'd1;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      load    = 1'b0;
      advance = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE:   state_n = full_eff[rbank] ? LOAD : IDLE;
         LOAD: begin
            load    = 1'b1;
            state_n = STREAM;
         end
         STREAM: if (y_valid && y_ready) begin
            done    = y_last;
            advance = !y_last;
            state_n = y_last ? (full_eff[~rbank] ? LOAD : IDLE) : STREAM;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         drop      <= 1'b0;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         full      <= 2'b00;
         overflow  <= 1'b0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_bank   <= 1'b0;
         s1_i      <= '0;
         s1_j      <= '0;
         s1_sample <= '0;
         y_data    <= '0;
         y_idx     <= '0;
         y_valid   <= 1'b0;
         y_last    <= 1'b0;
      end else begin
         if (wso_valid) cnt <= cnt + 9'd1;
         if (start) drop <= !wb_free;
         if (start && !wb_free) overflow <= 1'b1;
         s1_valid  <= take;
         s1_last   <= cnt == 9'd511;
         s1_bank   <= wb;
         s1_i      <= cnt[5:0];
         s1_j      <= cnt[8:6];
         s1_sample <= ACC_W'(windowed_sample);
         if (set_any) wbank <= ~wbank;
         full <= (full & ~clr_mask) | set_mask;
         if (done) rbank <= ~rbank;
         if (load || advance) begin
            y_data  <= acc[{rbank, rd_idx}];
            y_idx   <= rd_idx;
            y_last  <= rd_idx == 6'd63;
            y_valid <= 1'b1;
         end else if (done) begin
            y_valid <= 1'b0;
            y_last  <= 1'b0;
         end
      end
   end
   // The same acc[i] recurs only 64 valids later, so the RMW needs no forwarding.
   always_ff @(posedge clk) begin
      s1_rd <= acc[{wb, cnt[5:0]}];
      if (s1_valid) acc[{s1_bank, s1_i}] <= s1_j == 3'd0 ? s1_sample : s1_rd + s1_sample;
   end
endmodule

// File: tb/tb_polyphase_partial_sum.sv
// tb_polyphase_partial_sum: directed frames with hand-computed partial sums, checking order,
// latency, backpressure hold, ping-pong overflow and reset recovery.
module tb_polyphase_partial_sum;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic signed [15:0] windowed_sample = '0;
   logic wso_valid = 1'b0;
   logic signed [18:0] y_data;
   logic [5:0] y_idx;
   logic y_valid, y_last, overflow;
   logic y_ready = 1'b0;
   logic bp = 1'b0;
   logic rdy_hold = 1'b1;
   int tests = 0;
   int failed = 0;
   int q_data[$];
   int q_idx[$];
   int q_last[$];
   logic prev_stall = 1'b0;
   int prev_d = 0;
   int prev_i = 0;
   int prev_l = 0;

   polyphase_partial_sum dut (
      .clk(clk), .rst(rst), .windowed_sample(windowed_sample), .wso_valid(wso_valid),
      .y_data(y_data), .y_idx(y_idx), .y_valid(y_valid), .y_ready(y_ready),
      .y_last(y_last), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) y_ready <= bp ? 1'($urandom_range(0, 1)) : rdy_hold;

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Beats are recorded mid-cycle, where y_valid/y_ready are stable before the accepting edge.
   always @(negedge clk) begin
      if (rst && prev_stall) begin
         chk("hold_valid", int'(y_valid), 1);
         chk("hold_data", int'(y_data), prev_d);
         chk("hold_idx", int'(y_idx), prev_i);
         chk("hold_last", int'(y_last), prev_l);
      end
      if (rst && y_valid && y_ready) begin
         q_data.push_back(int'(y_data));
         q_idx.push_back(int'(y_idx));
         q_last.push_back(int'(y_last));
      end
      prev_stall <= rst && y_valid && !y_ready;
      prev_d <= int'(y_data);
      prev_i <= int'(y_idx);
      prev_l <= int'(y_last);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ramp Z[n]=n; mode 1: constant val. One valid every gap cycles.
   task automatic send_frame(input int mode, input int val, input int gap, input int nsamp);
      for (int n = 0; n < nsamp; n++) begin
         windowed_sample = 16'(mode == 0 ? n : val);
         wso_valid = 1'b1;
         tick();
         wso_valid = 1'b0;
         repeat (gap - 1) tick();
      end
   endtask

   task automatic drain_check(input string tag, input int b0, input int b1, input int step, input int n);
      int w = 0;
      while (q_data.size() < n && w < 3000) begin
         tick();
         w++;
      end
      repeat (20) tick();
      chk({tag, " beats"}, q_data.size(), n);
      for (int k = 0; k < n && k < q_data.size(); k++) begin
         chk($sformatf("%s data%0d", tag, k), q_data[k], (k < 64 ? b0 : b1) + step * (k % 64));
         chk($sformatf("%s idx%0d", tag, k), q_idx[k], k % 64);
         chk($sformatf("%s last%0d", tag, k), q_last[k], int'(k % 64 == 63));
      end
      q_data.delete();
      q_idx.delete();
      q_last.delete();
   endtask

   initial begin
      int w;
      rdy_hold = 1'b1;
      repeat (2) tick();
      chk("rst y_valid", int'(y_valid), 0);
      chk("rst y_last", int'(y_last), 0);
      chk("rst y_idx", int'(y_idx), 0);
      chk("rst y_data", int'(y_data), 0);
      chk("rst overflow", int'(overflow), 0);
      rst = 1'b1;
      tick();

      send_frame(0, 0, 1, 512);
      chk("lat n+1", int'(y_valid), 0);
      tick();
      chk("lat n+2", int'(y_valid), 0);
      tick();
      chk("lat n+3", int'(y_valid), 1);
      drain_check("ramp", 1792, 1792, 8, 64);

      send_frame(1, -32768, 1, 512);
      drain_check("min", -262144, -262144, 0, 64);
      send_frame(1, 32767, 1, 512);
      drain_check("max", 262136, 262136, 0, 64);
      chk("ovf extremes", int'(overflow), 0);

      bp = 1'b1;
      send_frame(0, 0, 1, 512);
      drain_check("bp", 1792, 1792, 8, 64);
      bp = 1'b0;

      rdy_hold = 1'b0;
      repeat (2) tick();
      send_frame(1, 1, 1, 512);
      send_frame(1, 2, 1, 512);
      chk("ovf before f3", int'(overflow), 0);
      for (int n = 0; n < 512; n++) begin
         windowed_sample = 16'sd3;
         wso_valid = 1'b1;
         tick();
         wso_valid = 1'b0;
         if (n == 0) chk("ovf at f3", int'(overflow), 1);
      end
      chk("stalled beats", q_data.size(), 0);
      rdy_hold = 1'b1;
      drain_check("pingpong", 8, 16, 0, 128);

      send_frame(0, 0, 3, 512);
      drain_check("gapped", 1792, 1792, 8, 64);

      send_frame(0, 0, 1, 200);
      rst = 1'b0;
      #1;
      chk("midframe rst valid", int'(y_valid), 0);
      chk("midframe rst ovf", int'(overflow), 0);
      tick();
      rst = 1'b1;
      tick();
      send_frame(0, 0, 1, 512);
      drain_check("after midframe", 1792, 1792, 8, 64);

      send_frame(0, 0, 1, 512);
      w = 0;
      while (q_data.size() < 20 && w < 500) begin
         tick();
         w++;
      end
      chk("middrain reached", int'(q_data.size() >= 20), 1);
      rst = 1'b0;
      #1;
      chk("middrain rst valid", int'(y_valid), 0);
      q_data.delete();
      q_idx.delete();
      q_last.delete();
      repeat (3) tick();
      rst = 1'b1;
      repeat (100) tick();
      chk("no stale beat", q_data.size(), 0);
      send_frame(0, 0, 1, 512);
      drain_check("after middrain", 1792, 1792, 8, 64);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
